// File: rtl/sha3_digest_serializer.sv
// sha3_digest_serializer
//
// Sits behind the sha3 core. When a finished digest is offered on
// md_out/res_valid it is captured in one cycle, acknowledged with a
// single-cycle res_ready pulse, and then streamed out most-significant
// byte first over a valid/ready byte interface.
//
// Build option:
//   SHA3_SER_HEX_EN  when defined, every byte goes out as two lowercase
//                    ASCII hex characters (high nibble first), so a digest
//                    takes MDLEN/4 beats. Undefined (the default): raw
//                    bytes, MDLEN/8 beats.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   md_out     digest from sha3, valid while res_valid is high
//   res_valid  digest available
//   res_ready  one-cycle capture acknowledge
//   out_data   output byte / ASCII character
//   out_valid  out_data valid
//   out_ready  sink accepts the current beat
//   out_last   final beat of the digest
//   busy       high while a digest is being streamed
//   dig_count  digests captured since reset (wraps at 2^16)

module sha3_digest_serializer #(
  parameter int MDLEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MDLEN-1:0] md_out,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      dig_count
);

`ifdef SHA3_SER_HEX_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 8;
`endif
  localparam int BEATS = MDLEN / STEP;
  localparam int CNTW  = $clog2(BEATS) + 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic [MDLEN-1:0]  shreg, shreg_nxt;
  logic [CNTW-1:0]   beat_cnt;
  logic              capture, accept, final_beat;
  logic [7:0]        data_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

  // armed blocks a second capture of a digest whose producer keeps
  // res_valid high after the acknowledge; it re-arms only once res_valid
  // has been seen low. Capture is only considered in IDLE, so the edge
  // that accepts the final beat can never capture.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    capture    = (state == IDLE) && armed && res_valid;
    accept     = (state == SEND) && out_valid && out_ready;
    final_beat = accept && (beat_cnt == LAST_BEAT);

    case (state)
      IDLE:    if (capture)    state_nxt = SEND;
      SEND:    if (final_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (capture)     shreg_nxt = md_out;
    else if (accept) shreg_nxt = shreg << STEP;

    // out_data is registered, so it is computed from the value the shift
    // register is about to take.
`ifdef SHA3_SER_HEX_EN
    data_nxt = hex_char(shreg_nxt[MDLEN-1 -: 4]);
`else
    data_nxt = shreg_nxt[MDLEN-1 -: 8];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      armed     <= 1'b1;
      beat_cnt  <= '0;
      res_ready <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      dig_count <= 16'h0000;
    end else begin
      res_ready <= capture;
      shreg     <= shreg_nxt;

      if (capture)         armed <= 1'b0;
      else if (!res_valid) armed <= 1'b1;

      if (capture) begin
        out_valid <= 1'b1;
        out_last  <= (LAST_BEAT == '0);
        beat_cnt  <= '0;
        out_data  <= data_nxt;
        dig_count <= dig_count + 16'd1;
      end else if (final_beat) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        beat_cnt  <= '0;
      end else if (accept) begin
        beat_cnt  <= beat_cnt + CNTW'(1);
        out_last  <= ((beat_cnt + CNTW'(1)) == LAST_BEAT);
        out_data  <= data_nxt;
      end
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb_sha3_digest_serializer
//
// Scoreboard bench for sha3_digest_serializer (MDLEN=256). Expected beats
// are pushed when a digest is offered and compared, front of queue, on
// every cycle the DUT presents a beat. Follows SHA3_SER_HEX_EN the same
// way the design does.

module tb_sha3_digest_serializer;

  localparam int MDLEN = 256;
`ifdef SHA3_SER_HEX_EN
  localparam int BEATS = MDLEN / 4;
`else
  localparam int BEATS = MDLEN / 8;
`endif

  localparam logic [MDLEN-1:0] DIG_A =
    256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;
  localparam logic [MDLEN-1:0] DIG_B =
    256'h0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a00ff00ff80000001;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [MDLEN-1:0] md_out;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [15:0]      dig_count;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    neg_idx  = 0;
  int    rr_count = 0;
  int    beat_seen = 0;
  int    last_beat_neg = 0;
  int    gap_last = 0;
  int    exp_rr  = 0;
  int    exp_dig = 0;

  sha3_digest_serializer #(.MDLEN(MDLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .md_out    (md_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dig_count (dig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'ha: c = 8'h61;  4'hb: c = 8'h62;  4'hc: c = 8'h63;
      4'hd: c = 8'h64;  4'he: c = 8'h65;  4'hf: c = 8'h66;
      default: c = 8'h30 + {4'h0, n};
    endcase
    return c;
  endfunction

  task automatic pushDigest(input logic [MDLEN-1:0] d);
    beat_t b;
    for (int i = 0; i < BEATS; i++) begin
`ifdef SHA3_SER_HEX_EN
      b.data = hexc(d[MDLEN-1-4*i -: 4]);
`else
      b.data = d[MDLEN-1-8*i -: 8];
`endif
      b.last = (i == BEATS - 1);
      exp_q.push_back(b);
    end
    exp_rr++;
    exp_dig++;
  endtask

  // Pulses res_valid for one cycle with digest d and records the expectation.
  task automatic applyStimulus(input logic [MDLEN-1:0] d);
    md_out    = d;
    res_valid = 1'b1;
    pushDigest(d);
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  // Drives out_ready from a 4-cycle pattern until the scoreboard empties.
  task automatic waitDrain(input logic [3:0] pat);
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 3000) begin
      out_ready = pat[cyc % 4];
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
    checkOutput("busy_after", {31'b0, busy}, 0);
  endtask

  // Monitor: every beat on offer is compared to the queue front, so stalled
  // cycles also prove the data is being held.
  always @(negedge clk) begin
    if (rst) begin
      neg_idx++;
      if (res_ready) begin
        rr_count++;
        gap_last = neg_idx - last_beat_neg;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", {24'b0, out_data}, 32'hffff_ffff);
        end else begin
          checkOutput("out_data", {24'b0, out_data}, {24'b0, exp_q[0].data});
          checkOutput("out_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
          if (out_ready) begin
            beat_seen++;
            if (exp_q[0].last) last_beat_neg = neg_idx;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        checkOutput("last_idle", {31'b0, out_last}, 0);
      end
    end
  end

  initial begin
    int cyc;
    int base;
    rst = 1'b0; res_valid = 1'b0; out_ready = 1'b0; md_out = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_res_ready", {31'b0, res_ready}, 0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_out_last",  {31'b0, out_last}, 0);
    checkOutput("rst_out_data",  {24'b0, out_data}, 0);
    checkOutput("rst_busy",      {31'b0, busy}, 0);
    checkOutput("rst_dig_count", {16'b0, dig_count}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Nominal transfer with capture latency checks.
    $display("[TB] nominal");
    out_ready = 1'b1;
    applyStimulus(DIG_A);
    checkOutput("cap_res_ready", {31'b0, res_ready}, 1);
    checkOutput("cap_out_valid", {31'b0, out_valid}, 1);
    checkOutput("cap_busy",      {31'b0, busy}, 1);
    waitDrain(4'b1111);
    checkOutput("nom_captures",  rr_count, exp_rr);
    checkOutput("nom_dig_count", {16'b0, dig_count}, exp_dig);

    // Backpressure 1,0,0,1 repeating.
    $display("[TB] backpressure");
    applyStimulus(DIG_A);
    waitDrain(4'b1001);
    checkOutput("bp_captures",  rr_count, exp_rr);
    checkOutput("bp_dig_count", {16'b0, dig_count}, exp_dig);

    // Sticky res_valid: one capture over 100 cycles, then a re-raise.
    $display("[TB] sticky");
    md_out = DIG_B; res_valid = 1'b1; out_ready = 1'b1;
    pushDigest(DIG_B);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("sticky_captures",  rr_count, exp_rr);
    checkOutput("sticky_dig_count", {16'b0, dig_count}, exp_dig);
    res_valid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(DIG_A);
    waitDrain(4'b1111);
    checkOutput("rearm_captures",  rr_count, exp_rr);
    checkOutput("rearm_dig_count", {16'b0, dig_count}, exp_dig);

    // Reset after the tenth accepted beat.
    $display("[TB] reset mid-transfer");
    base = beat_seen;
    applyStimulus(DIG_B);
    cyc = 0;
    while (beat_seen < base + 10 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("beats_before_rst", beat_seen - base, 10);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("abort_out_valid", {31'b0, out_valid}, 0);
    checkOutput("abort_busy",      {31'b0, busy}, 0);
    checkOutput("abort_dig_count", {16'b0, dig_count}, 0);
    exp_dig = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(DIG_A);
    waitDrain(4'b1111);
    checkOutput("post_rst_dig_count", {16'b0, dig_count}, exp_dig);

    // Back-to-back: second request raised while the first is streaming.
    $display("[TB] back-to-back");
    applyStimulus(DIG_A);
    repeat (5) @(posedge clk);
    #1;
    md_out = DIG_B; res_valid = 1'b1;
    pushDigest(DIG_B);
    cyc = 0;
    while (rr_count < exp_rr && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    res_valid = 1'b0;
    checkOutput("b2b_captures", rr_count, exp_rr);
    checkOutput("b2b_gap_ok", {31'b0, (gap_last >= 2)}, 1);
    waitDrain(4'b1111);
    checkOutput("b2b_dig_count", {16'b0, dig_count}, exp_dig);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
